// File: rtl/bcd_sseg_loader_pkg.sv
// Display geometry defaults and FSM encodings shared by the sseg loader and the top level.
package bcd_sseg_loader_pkg;

  localparam int DEF_BCD_N     = 4;
  localparam int DEF_SSEG_BITS = 5;
  localparam int DEF_SSEG_N    = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/bcd_sseg_loader.sv
// Copies a signed BCD result into consecutive sseg_array slots with blanking, dp and sign.
// Latency: start in cycle 0, slots in cycles 1..BCD_N, done_tick in BCD_N+1, ready again in BCD_N+2.
// Backpressure: none downstream; start is only honoured while ready=1 and is never queued.
module bcd_sseg_loader
  import bcd_sseg_loader_pkg::*;
#(
  parameter int BCD_N     = DEF_BCD_N,
  parameter int SSEG_BITS = DEF_SSEG_BITS,
  parameter int SSEG_N    = DEF_SSEG_N
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SSEG_BITS-1:0]   base_sel,
  input  logic [4*BCD_N-1:0]     bcd,
  input  logic                   sign,
  input  logic                   dp_en,
  input  logic [1:0]             dp_pos,
  input  logic                   blank_lz,
  output logic                   ready,
  output logic                   done_tick,
  output logic                   wr,
  output logic [SSEG_BITS-1:0]   sel,
  output logic                   en,
  output logic                   o_sign,
  output logic                   dp,
  output logic [3:0]             val
);

  localparam int KW = (BCD_N > 1) ? $clog2(BCD_N) : 1;

  // Bit k set means digit k stays visible; blanked digits always form a contiguous top run.
  function automatic logic [BCD_N-1:0] en_mask(input logic [4*BCD_N-1:0] d,
                                                input logic               blz,
                                                input logic [1:0]         dpp);
    logic [BCD_N-1:0] m;
    logic             zero_above;
    int               dpe;
    dpe        = (int'(dpp) >= BCD_N) ? BCD_N - 1 : int'(dpp);
    zero_above = 1'b1;
    m          = '1;
    for (int i = BCD_N - 1; i >= 1; i--) begin
      zero_above = zero_above && (d[4*i +: 4] == 4'd0);
      if (blz && zero_above && (i > dpe)) m[i] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [KW-1:0] top_idx(input logic [BCD_N-1:0] m);
    logic [KW-1:0] t;
    t = '0;
    for (int i = 0; i < BCD_N; i++) begin
      if (m[i]) t = KW'(i);
    end
    return t;
  endfunction

  logic [1:0]           state;
  logic [KW-1:0]        k;
  logic [SSEG_BITS-1:0] base_q;
  logic [4*BCD_N-1:0]   bcd_q;
  logic                 sign_q;
  logic                 dp_en_q;
  logic [1:0]           dp_pos_q;
  logic [BCD_N-1:0]     mask_q;

  logic                 idle;
  logic [SSEG_BITS-1:0] src_base;
  logic [4*BCD_N-1:0]   src_bcd;
  logic                 src_sign;
  logic                 src_dp_en;
  logic [1:0]           src_dp_pos;
  logic [BCD_N-1:0]     src_mask;
  logic [KW-1:0]        nidx;
  logic [SSEG_BITS-1:0] nsel;
  logic [3:0]           nval;
  logic                 nwr;
  logic                 nen;
  logic                 nsign;
  logic                 ndp;

  // Slot 0 is produced on the start edge straight from the inputs; later slots use the latched copy.
  always_comb begin
    idle       = (state == ST_IDLE);
    src_base   = idle ? base_sel : base_q;
    src_bcd    = idle ? bcd      : bcd_q;
    src_sign   = idle ? sign     : sign_q;
    src_dp_en  = idle ? dp_en    : dp_en_q;
    src_dp_pos = idle ? dp_pos   : dp_pos_q;
    src_mask   = idle ? en_mask(bcd, blank_lz, dp_pos) : mask_q;
    nidx       = idle ? '0 : k + KW'(1);
    nsel       = src_base + SSEG_BITS'(nidx);
    nval       = src_bcd[4*nidx +: 4];
    nwr        = (32'(nsel) < SSEG_N);
    nen        = src_mask[nidx];
    nsign      = src_sign && (nidx == top_idx(src_mask));
    ndp        = src_dp_en && (32'(nidx) == 32'(src_dp_pos));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      k         <= '0;
      base_q    <= '0;
      bcd_q     <= '0;
      sign_q    <= 1'b0;
      dp_en_q   <= 1'b0;
      dp_pos_q  <= '0;
      mask_q    <= '0;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      wr        <= 1'b0;
      sel       <= '0;
      en        <= 1'b0;
      o_sign    <= 1'b0;
      dp        <= 1'b0;
      val       <= '0;
    end else begin
      done_tick <= 1'b0;
      wr        <= 1'b0;
      sel       <= '0;
      en        <= 1'b0;
      o_sign    <= 1'b0;
      dp        <= 1'b0;
      val       <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q   <= base_sel;
            bcd_q    <= bcd;
            sign_q   <= sign;
            dp_en_q  <= dp_en;
            dp_pos_q <= dp_pos;
            mask_q   <= src_mask;
            k        <= '0;
            state    <= ST_WRITE;
            ready    <= 1'b0;
            wr       <= nwr;
            sel      <= nsel;
            en       <= nen;
            o_sign   <= nsign;
            dp       <= ndp;
            val      <= nval;
          end
        end
        ST_WRITE: begin
          // k names the slot currently on the outputs.
          if (k == KW'(BCD_N - 1)) begin
            done_tick <= 1'b1;
            state     <= ST_DONE;
          end else begin
            k      <= nidx;
            wr     <= nwr;
            sel    <= nsel;
            en     <= nen;
            o_sign <= nsign;
            dp     <= ndp;
            val    <= nval;
          end
        end
        ST_DONE: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sseg_loader.sv
// Directed bench for bcd_sseg_loader with a cycle-indexed expectation model and literal pins.
module tb_bcd_sseg_loader;

  typedef struct packed {
    logic       ready;
    logic       done;
    logic       wr;
    logic [4:0] sel;
    logic       en;
    logic       sgn;
    logic       dp;
    logic [3:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  base_sel;
  logic [15:0] bcd;
  logic        sign;
  logic        dp_en;
  logic [1:0]  dp_pos;
  logic        blank_lz;
  logic        ready, done_tick, wr, en, o_sign, dp;
  logic [4:0]  sel;
  logic [3:0]  val;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_on  = 0;
  exp_t sched [int];

  bcd_sseg_loader dut (
    .clk(clk), .reset(reset), .start(start), .base_sel(base_sel), .bcd(bcd),
    .sign(sign), .dp_en(dp_en), .dp_pos(dp_pos), .blank_lz(blank_lz),
    .ready(ready), .done_tick(done_tick), .wr(wr), .sel(sel), .en(en),
    .o_sign(o_sign), .dp(dp), .val(val)
  );

  always #5 clk = ~clk;

  function automatic exp_t exp_at(input int n);
    exp_t e;
    e = '0;
    e.ready = 1'b1;
    if (sched.exists(n)) e = sched[n];
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Model: a display of BCD_N digits shows everything up to the highest of
  // (most significant nonzero digit, dp digit, digit 0); the sign sits on that top digit.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i <= 6; i++)
        if (sched.exists(cyc + i)) sched.delete(cyc + i);
    end else if (start && exp_at(cyc).ready) begin
      int hn, dpe, top, s;
      int dig [4];
      hn = 0;
      for (int i = 0; i < 4; i++) begin
        dig[i] = int'(bcd[4*i +: 4]);
        if (dig[i] != 0) hn = i;
      end
      dpe = int'(dp_pos);
      top = blank_lz ? ((hn > dpe) ? hn : dpe) : 3;
      for (int kk = 0; kk < 4; kk++) begin
        exp_t e;
        e       = '0;
        s       = (int'(base_sel) + kk) % 32;
        e.sel   = 5'(s);
        e.wr    = (s < 16);
        e.val   = 4'(dig[kk]);
        e.en    = (kk <= top);
        e.sgn   = sign && (kk == top);
        e.dp    = dp_en && (kk == int'(dp_pos));
        sched[cyc + 1 + kk] = e;
      end
      begin
        exp_t d;
        d = '0;
        d.done = 1'b1;
        sched[cyc + 5] = d;
      end
    end
    chk_on = 1;
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      exp_t a;
      a = '{ready, done_tick, wr, sel, en, o_sign, dp, val};
      chk("model_outputs", 32'(a), 32'(exp_at(cyc)));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [4:0] b, input logic [15:0] v, input logic s,
                           input logic de, input logic [1:0] dpp, input logic blz);
    base_sel = b; bcd = v; sign = s; dp_en = de; dp_pos = dpp; blank_lz = blz;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  initial begin
    int nwr, ndone;
    logic [4:0] e_sel [4];
    logic [3:0] e_val [4];
    logic       e_en  [4];
    logic       e_dp  [4];
    logic       e_sg  [4];
    logic       e_wr  [4];

    reset = 1'b1; start = 1'b0; base_sel = '0; bcd = '0; sign = 1'b0;
    dp_en = 1'b0; dp_pos = '0; blank_lz = 1'b0;
    next_cycle(); next_cycle();
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_wr", 32'(wr), 32'd0);
    // reset wins over a simultaneous start
    start = 1'b1;
    next_cycle();
    chk("rst_start_wr", 32'(wr), 32'd0);
    next_cycle();
    chk("rst_start_ready", 32'(ready), 32'd1);
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      chk("idle_ready", 32'(ready), 32'd1);
      chk("idle_wr", 32'(wr), 32'd0);
      chk("idle_done", 32'(done_tick), 32'd0);
    end

    // 0123, blanking, base 4
    e_sel = '{5'd4, 5'd5, 5'd6, 5'd7};
    e_val = '{4'd3, 4'd2, 4'd1, 4'd0};
    e_en  = '{1'b1, 1'b1, 1'b1, 1'b0};
    start_seq(5'd4, 16'h0123, 1'b0, 1'b0, 2'd0, 1'b1);
    for (int kk = 0; kk < 4; kk++) begin
      chk("s2_wr", 32'(wr), 32'd1);
      chk("s2_sel", 32'(sel), 32'(e_sel[kk]));
      chk("s2_val", 32'(val), 32'(e_val[kk]));
      chk("s2_en", 32'(en), 32'(e_en[kk]));
      next_cycle();
    end
    chk("s2_done", 32'(done_tick), 32'd1);
    chk("s2_ready_c5", 32'(ready), 32'd0);
    next_cycle();
    chk("s2_ready_c6", 32'(ready), 32'd1);
    chk("s2_done_c6", 32'(done_tick), 32'd0);
    next_cycle();

    // negative 5 with dp on digit 1
    e_en = '{1'b1, 1'b1, 1'b0, 1'b0};
    e_dp = '{1'b0, 1'b1, 1'b0, 1'b0};
    e_sg = '{1'b0, 1'b1, 1'b0, 1'b0};
    start_seq(5'd0, 16'h0005, 1'b1, 1'b1, 2'd1, 1'b1);
    for (int kk = 0; kk < 4; kk++) begin
      chk("s3_en", 32'(en), 32'(e_en[kk]));
      chk("s3_dp", 32'(dp), 32'(e_dp[kk]));
      chk("s3_sign", 32'(o_sign), 32'(e_sg[kk]));
      next_cycle();
    end
    next_cycle(); next_cycle();

    // out-of-range slots at the top of the array
    e_sel = '{5'd14, 5'd15, 5'd16, 5'd17};
    e_wr  = '{1'b1, 1'b1, 1'b0, 1'b0};
    e_val = '{4'd1, 4'd2, 4'd3, 4'd4};
    start_seq(5'd14, 16'h4321, 1'b1, 1'b0, 2'd0, 1'b0);
    for (int kk = 0; kk < 4; kk++) begin
      chk("s4_sel", 32'(sel), 32'(e_sel[kk]));
      chk("s4_wr", 32'(wr), 32'(e_wr[kk]));
      chk("s4_val", 32'(val), 32'(e_val[kk]));
      chk("s4_sign", 32'(o_sign), (kk == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    chk("s4_done", 32'(done_tick), 32'd1);
    next_cycle(); next_cycle();

    // reset in cycle 2 aborts
    start_seq(5'd0, 16'h9876, 1'b0, 1'b0, 2'd0, 1'b0);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    chk("s5_wr_after_rst", 32'(wr), 32'd0);
    chk("s5_ready_after_rst", 32'(ready), 32'd1);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      ndone += int'(done_tick) + int'(wr);
      next_cycle();
    end
    chk("s5_no_activity", 32'(ndone), 32'd0);
    start_seq(5'd2, 16'h0042, 1'b0, 1'b0, 2'd0, 1'b1);
    next_cycle(); next_cycle(); next_cycle(); next_cycle();
    chk("s5_restart_done", 32'(done_tick), 32'd1);
    next_cycle(); next_cycle();

    // repeated start while busy
    start_seq(5'd8, 16'h1111, 1'b0, 1'b0, 2'd0, 1'b0);
    start = 1'b1;
    nwr = 0; ndone = 0;
    for (int c = 1; c <= 8; c++) begin
      nwr   += int'(wr);
      ndone += int'(done_tick);
      if (c == 4) start = 1'b0;
      next_cycle();
    end
    chk("s6_writes", 32'(nwr), 32'd4);
    chk("s6_dones", 32'(ndone), 32'd1);

    // zero with blanking, dp forcing width, wrap-around, no blanking
    start_seq(5'd0, 16'h0000, 1'b1, 1'b0, 2'd0, 1'b1);
    chk("zero_en0", 32'(en), 32'd1);
    chk("zero_sign0", 32'(o_sign), 32'd1);
    next_cycle();
    chk("zero_en1", 32'(en), 32'd0);
    repeat (5) next_cycle();
    start_seq(5'd31, 16'h0000, 1'b1, 1'b1, 2'd3, 1'b1);
    chk("wrap_sel0", 32'(sel), 32'd31);
    chk("wrap_wr0", 32'(wr), 32'd0);
    next_cycle();
    chk("wrap_sel1", 32'(sel), 32'd0);
    chk("wrap_wr1", 32'(wr), 32'd1);
    repeat (5) next_cycle();
    start_seq(5'd10, 16'h0700, 1'b1, 1'b1, 2'd0, 1'b0);
    repeat (7) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
